muxn_rr_arbiter: RTL and testbench
==================================

# muxn_rr_arbiter

Round-robin arbiter and output register that shares one N-way, WIDTH-bit `commonlib_muxn` datapath among N valid/ready requesters. It computes the mux select from pending requests and drives the mux. It registers the selected word plus its source index into a single output stage with valid/ready flow control. It sits between N producer streams and one downstream consumer. An optional packet-lock mode keeps the grant until a packet's last beat.

## Interface
- `N`, default 5: number of requesters; N ≥ 1.
- `WIDTH`, default 32: data width.
- `SEL_W`, default `$clog2(N)`, minimum 1: width of the select and index fields.

- `CLK`  input  1  clock; all state updates on the rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `in_valid`  input  N  per-requester valid.
- `in_ready`  output  N  per-requester ready; combinational; at most one bit high.
- `in_data`  input  WIDTH × [N-1:0] unpacked array  per-requester data.
- `in_last`  input  N  per-requester end-of-packet flag.
- `out_valid`  output  1  output register holds a beat.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  WIDTH  registered selected word.
- `out_sel`  output  SEL_W  index of the requester that produced `out_data`.
- `out_last`  output  1  registered `in_last` of that beat.

## Operation
- `load_en = !out_valid || out_ready`.
- Priority search starts at pointer `ptr` and proceeds `ptr`, `ptr+1`, …, wrapping modulo N (not 2^SEL_W).
  - The first requester with `in_valid` high is grant `g`.
  - The search drives the muxn select.
- `in_ready[i] = load_en && grant && i == g && !RESET`.
- Transfer from requester g happens when `in_valid[g] && in_ready[g]`. On transfer:
  - `out_valid` ← 1.
  - `out_data` ← `in_data[g]`.
  - `out_sel` ← g.
  - `out_last` ← `in_last[g]`.
- If `load_en` is high and there is no grant, `out_valid` ← 0. `out_data`, `out_sel` and `out_last` hold.
- If `load_en` is low, everything holds, `in_ready` is all 0 and `ptr` is unchanged.
- Pointer update: on an arbitration-completing transfer, `ptr` ← (g+1) mod N. With g = N-1, `ptr` ← 0.
- Simultaneous events: when `out_ready` and a new grant occur in the same cycle, the register is drained and refilled in that cycle with no bubble.
- N = 1: requester 0 is always the only candidate; `out_sel` is always 0.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0, `ptr`=0, state=ARB, `in_ready`=0.
- Reset mid-operation discards any held beat and any lock.

## Timing
- Latency: input transfer at edge k makes `out_valid` high after edge k.
- Throughput: 1 beat per cycle while `out_ready` is high.
- `in_ready` depends combinationally on `in_valid`, `out_ready`, `out_valid`, `ptr` and state. It must not depend on `in_data`.
- `out_*` signals are pure register outputs.
- The first transfer possible is in the first cycle with `RESET` low.

## Configuration
- Macro: `MUXN_ARB_LOCK_EN`.
- **Defined:** two-state FSM with states ARB and LOCK, plus an owner register.
  - ARB → LOCK on transfer from g with `in_last[g]`=0; owner ← g; `ptr` unchanged.
  - In LOCK only the owner is a candidate. `in_ready[owner] = load_en`. Other requesters are ignored.
  - LOCK → ARB on transfer from the owner with `in_last`=1. At that transfer `ptr` ← (owner+1) mod N.
  - A single-beat packet (`in_last`=1 on its first beat) stays in ARB and advances `ptr` normally.
- **Undefined:** no FSM. Every transfer completes arbitration and advances `ptr`. `in_last` is passed through to `out_last` only.

## Structure
- Package `muxn_arb_pkg` contains:
  - the state enum `arb_state_t` (ARB, LOCK);
  - the function `sel_w(n)`, returning max(1, $clog2(n)).
- Sub-module `muxn_rr_pick` provides the combinational rotate-priority pick.
  - Inputs: req[N], ptr, optional mask.
  - Outputs: grant index and any-grant flag.
- The datapath instantiates `commonlib_muxn` (N, WIDTH), with `in_sel` driven by the grant index.

## Test plan
N=5, WIDTH=32, `in_data[i]` = 32'hA000_0000+i unless noted.
- Reset: hold `RESET` for 2 cycles with all `in_valid`=1 → `in_ready`=0 and `out_valid`=0 throughout. The first cycle after release grants 0, and the next cycle shows `out_data`=32'hA000_0000 with `out_sel`=0.
- Fairness: all valid, `out_ready`=1 → `out_sel` sequence 0,1,2,3,4,0,1 with no bubbles.
- Wrap: only requesters 4 and 0 valid with `ptr`=3 → grants 4, then 0, then 4. `ptr` goes 0, 1, 0.
- Backpressure: `out_ready`=0 for 3 cycles while `out_valid`=1 → `out_data`/`out_sel` stable, `in_ready`=0, `ptr` unchanged. The cycle `out_ready` returns to 1 accepts the next grant in the same cycle.
- Lock (`MUXN_ARB_LOCK_EN`): requester 2 sends 3 beats with `in_last` pattern 0,0,1 while requester 1 holds `in_valid` → `out_sel` 2,2,2,3… if 3 is valid, otherwise 2,2,2,4,0,1 per valid set. Requester 1 is never granted mid-packet. Without the macro, the same stimulus interleaves grants.
- Reset mid-operation: assert `RESET` while LOCK is active and `out_valid`=1 stalled → the next cycle shows `out_valid`=0, state ARB and `ptr`=0. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/muxn_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The packet-lock build is selected with the MUXN_ARB_LOCK_EN macro.
package muxn_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Select/index width; never narrower than one bit so N = 1 still has a port.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/commonlib_muxn.sv
// Plain N-way, WIDTH-bit combinational multiplexer.
// An out-of-range select yields zero.
module commonlib_muxn #(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [SEL_W-1:0] in_sel,
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SEL_W'(i)) begin
                out_data = in_data[i];
            end
        end
    end

endmodule

// File: rtl/muxn_rr_pick.sv
// Rotating-priority pick: first requester at or after ptr (mod N) that is
// both requesting and unmasked.
module muxn_rr_pick #(
    parameter int N     = 5,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr is always below N, so a single subtraction wraps the index.
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && req[idx] && mask[idx]) begin
                any_grant = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/muxn_rr_arbiter.sv
// Round-robin arbiter sharing one commonlib_muxn among N valid/ready streams,
// with a single registered output stage. MUXN_ARB_LOCK_EN adds packet lock.
module muxn_rr_arbiter
    import muxn_arb_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int SEL_W = sel_w(N)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [N-1:0]     in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_last,
    output arb_state_t       dbg_state,
    output logic [SEL_W-1:0] dbg_ptr
);

    // Handshake: a beat moves on any rising edge where valid and ready are both
    // high; valid never waits on ready, and ready never looks at data.

    logic             load_en;
    logic             transfer;
    logic             any_grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     mask;
    logic [WIDTH-1:0] mux_data;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

`ifdef MUXN_ARB_LOCK_EN
    arb_state_t       state;
    logic [SEL_W-1:0] owner;

    always_comb begin
        mask = '1;
        if (state == LOCK) begin
            mask        = '0;
            mask[owner] = 1'b1;
        end
    end

    assign dbg_state = state;
`else
    assign mask      = '1;
    assign dbg_state = ARB;
`endif

    muxn_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .mask      (mask),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    commonlib_muxn #(
        .N     (N),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .in_sel   (grant_idx),
        .out_data (mux_data)
    );

    assign load_en  = !out_valid || out_ready;
    assign transfer = load_en && any_grant && !RESET;
    assign dbg_ptr  = ptr;

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
`ifdef MUXN_ARB_LOCK_EN
            state     <= ARB;
            owner     <= '0;
`endif
        end else if (load_en) begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= grant_idx;
                out_last  <= in_last[grant_idx];
`ifdef MUXN_ARB_LOCK_EN
                if (state == ARB) begin
                    if (in_last[grant_idx]) begin
                        ptr <= next_idx(grant_idx);
                    end else begin
                        state <= LOCK;
                        owner <= grant_idx;
                    end
                end else if (in_last[grant_idx]) begin
                    // In LOCK the grant can only be the owner.
                    state <= ARB;
                    ptr   <= next_idx(owner);
                end
`else
                ptr <= next_idx(grant_idx);
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_rr_arbiter.sv
// Directed bench for muxn_rr_arbiter (N=5, WIDTH=32): expected beats are queued
// by the stimulus and popped by an output monitor. Honours MUXN_ARB_LOCK_EN.
module tb_muxn_rr_arbiter;
    import muxn_arb_pkg::*;

    localparam int N     = 5;
    localparam int WIDTH = 32;
    localparam int SEL_W = 3;
    localparam int EW    = 1 + SEL_W + WIDTH;

    logic             CLK;
    logic             RESET;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] in_data [N-1:0];
    logic [N-1:0]     in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_last;
    arb_state_t       dbg_state;
    logic [SEL_W-1:0] dbg_ptr;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    muxn_rr_arbiter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int sel, input bit last);
        logic [WIDTH-1:0] d;
        d = 32'hA000_0000 + WIDTH'(sel);
        return {last, SEL_W'(sel), d};
    endfunction

    // Scoreboard monitor: a beat is consumed when valid and ready meet.
    always @(negedge CLK) begin
        if (!RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {out_last, out_sel, out_data}, '0);
            end else begin
                chk("beat", {out_last, out_sel, out_data}, exp_q.pop_front());
            end
        end
    end

`ifdef MUXN_ARB_LOCK_EN
    localparam int LT = 4;
    logic [N-1:0] lk_last [LT] = '{5'b00010, 5'b00010, 5'b00110, 5'b00010};
    int           lk_sel  [LT] = '{2, 2, 2, 1};
    bit           lk_elast[LT] = '{0, 0, 1, 1};
    arb_state_t   lk_state[LT] = '{LOCK, LOCK, ARB, ARB};
    localparam int LK_PTR = 2;
    localparam int MR_PTR = 2;
    localparam arb_state_t MR_STATE = LOCK;
`else
    localparam int LT = 5;
    logic [N-1:0] lk_last [LT] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00110};
    int           lk_sel  [LT] = '{2, 1, 2, 1, 2};
    bit           lk_elast[LT] = '{0, 1, 0, 1, 1};
    arb_state_t   lk_state[LT] = '{ARB, ARB, ARB, ARB, ARB};
    localparam int LK_PTR = 3;
    localparam int MR_PTR = 3;
    localparam arb_state_t MR_STATE = ARB;
`endif

    initial begin
        int wrap_sel[4] = '{2, 4, 0, 4};
        int wrap_ptr[4] = '{3, 0, 1, 0};
        for (int i = 0; i < N; i++) in_data[i] = 32'hA000_0000 + WIDTH'(i);

        // Reset held with every requester valid
        RESET     = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready0", 64'(in_ready), 0);
        step();
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_in_ready1", 64'(in_ready), 0);
        chk("reset_out_data", 64'(out_data), 0);
        chk("reset_out_sel", 64'(out_sel), 0);
        chk("reset_out_last", 64'(out_last), 0);
        chk("reset_ptr", 64'(dbg_ptr), 0);
        chk("reset_state", 64'(dbg_state), 64'(ARB));
        step();
        chk("reset_out_valid2", 64'(out_valid), 0);
        RESET = 1'b0;
        #1;

        // Fairness: all valid, no bubbles
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(mk(k % 5, 1'b1));
            chk("fair_in_ready", 64'(in_ready), 64'(1 << (k % 5)));
            step();
            chk("fair_out_valid", 64'(out_valid), 1);
            chk("fair_out_sel", 64'(out_sel), 64'(k % 5));
        end
        in_valid = '0;
        step();
        step();
        chk("fair_drained", 64'(out_valid), 0);
        chk("fair_ptr", 64'(dbg_ptr), 2);

        // Wrap: bring ptr to 3, then only requesters 4 and 0
        for (int k = 0; k < 4; k++) begin
            in_valid = (k == 0) ? 5'b00100 : 5'b10001;
            exp_q.push_back(mk(wrap_sel[k], 1'b1));
            #1;
            chk("wrap_in_ready", 64'(in_ready), 64'(1 << wrap_sel[k]));
            step();
            chk("wrap_ptr", 64'(dbg_ptr), 64'(wrap_ptr[k]));
        end
        in_valid = '0;
        step();
        step();

        // Backpressure: hold the register for three cycles
        in_valid  = '1;
        out_ready = 1'b0;
        exp_q.push_back(mk(0, 1'b1));
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'b00001);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 64'(in_ready), 0);
            chk("bp_out_sel", 64'(out_sel), 0);
            chk("bp_out_data", 64'(out_data), 64'h0000_0000_A000_0000);
            chk("bp_ptr", 64'(dbg_ptr), 1);
            step();
        end
        out_ready = 1'b1;
        exp_q.push_back(mk(1, 1'b1));
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'b00010);
        step();
        chk("bp_refill_valid", 64'(out_valid), 1);
        chk("bp_refill_sel", 64'(out_sel), 1);
        in_valid = '0;
        step();
        step();

        // Packet of three beats from requester 2 while requester 1 waits
        for (int k = 0; k < LT; k++) begin
            in_valid = 5'b00110;
            in_last  = lk_last[k];
            exp_q.push_back(mk(lk_sel[k], lk_elast[k]));
            #1;
            chk("pkt_in_ready", 64'(in_ready), 64'(1 << lk_sel[k]));
            step();
            chk("pkt_state", 64'(dbg_state), 64'(lk_state[k]));
        end
        in_valid = '0;
        in_last  = '1;
        step();
        step();
        chk("pkt_ptr", 64'(dbg_ptr), 64'(LK_PTR));

        // Reset while a beat is stalled (and, with lock, mid-packet)
        in_valid  = 5'b00100;
        in_last   = 5'b00000;
        out_ready = 1'b0;
        step();
        chk("mr_held_valid", 64'(out_valid), 1);
        chk("mr_state", 64'(dbg_state), 64'(MR_STATE));
        chk("mr_ptr_before", 64'(dbg_ptr), 64'(MR_PTR));
        RESET = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready), 0);
        step();
        chk("mr_out_valid", 64'(out_valid), 0);
        chk("mr_state_arb", 64'(dbg_state), 64'(ARB));
        chk("mr_ptr", 64'(dbg_ptr), 0);
        RESET     = 1'b0;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        exp_q.push_back(mk(0, 1'b1));
        #1;
        chk("mr_restart_ready", 64'(in_ready), 64'b00001);
        step();
        chk("mr_restart_sel", 64'(out_sel), 0);
        in_valid = '0;
        step();
        step();

        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
